// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory-port arbiter, its two requesters
// (MM2S read, S2MM write) and the single-port memory.
interface mem_port_arbiter_if #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32
);
    localparam int LSB = $clog2(AXI_WIDTH) - 3;
    localparam int AW  = AXI_ADDR_WIDTH - LSB;
    localparam int SW  = AXI_WIDTH / 8;

    logic                 rd_req_valid;
    logic [AW-1:0]        rd_req_addr;
    logic                 rd_req_ready;
    logic                 rd_resp_valid;
    logic [AXI_WIDTH-1:0] rd_resp_data;

    logic                 wr_valid;
    logic [AW-1:0]        wr_addr;
    logic [AXI_WIDTH-1:0] wr_data;
    logic [SW-1:0]        wr_strb;
    logic                 wr_ready;

    logic                 mem_ren;
    logic                 mem_wen;
    logic [AW-1:0]        mem_addr;
    logic [AXI_WIDTH-1:0] mem_wdata;
    logic [SW-1:0]        mem_strb;
    logic [AXI_WIDTH-1:0] mem_rdata;

    // Environment side: requesters plus the memory array.
    modport master (
        output rd_req_valid, rd_req_addr, wr_valid, wr_addr, wr_data, wr_strb, mem_rdata,
        input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_ready,
               mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb
    );

    // Arbiter side.
    modport slave (
        input  rd_req_valid, rd_req_addr, wr_valid, wr_addr, wr_data, wr_strb, mem_rdata,
        output rd_req_ready, rd_resp_valid, rd_resp_data, wr_ready,
               mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port memory: alternates between
// read and write grants, limiting each grant to MAX_HOLD beats while the
// other side is waiting. Read data returns one cycle after acceptance.
module mem_port_arbiter #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_HOLD       = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int LSB = $clog2(AXI_WIDTH) - 3;
    localparam int AW  = AXI_ADDR_WIDTH - LSB;
    localparam int SW  = AXI_WIDTH / 8;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_t;
    typedef enum logic {LAST_RD, LAST_WR} last_t;

    state_t               state, state_next;
    last_t                last_gnt;
    logic [7:0]           beat_cnt;
    logic                 rd_rdy, wr_rdy, ren, wen, beat_acc, hold_done;
    logic [AW-1:0]        addr;
    logic [AXI_WIDTH-1:0] wdata;
    logic [SW-1:0]        strb;
    logic                 resp_valid;

    // Next-state selection and combinational grant outputs.
    always_comb begin
        state_next = state;
        rd_rdy     = 1'b0;
        wr_rdy     = 1'b0;
        ren        = 1'b0;
        wen        = 1'b0;
        addr       = '0;
        wdata      = '0;
        strb       = '0;
        beat_acc   = 1'b0;
        // >= rather than == so a grant that ran long while the other side
        // was idle still yields after its next beat once the other side asks.
        hold_done  = (beat_cnt >= HOLD_LAST);
        case (state)
            IDLE: begin
                if (bus.rd_req_valid && bus.wr_valid)
                    state_next = (last_gnt == LAST_WR) ? GNT_RD : GNT_WR;
                else if (bus.rd_req_valid)
                    state_next = GNT_RD;
                else if (bus.wr_valid)
                    state_next = GNT_WR;
            end
            GNT_RD: begin
                rd_rdy   = 1'b1;
                ren      = bus.rd_req_valid;
                addr     = bus.rd_req_addr;
                beat_acc = bus.rd_req_valid;
                if (!bus.rd_req_valid)
                    state_next = bus.wr_valid ? GNT_WR : IDLE;
                else if (hold_done && bus.wr_valid)
                    state_next = GNT_WR;
            end
            GNT_WR: begin
                wr_rdy   = 1'b1;
                wen      = bus.wr_valid;
                addr     = bus.wr_addr;
                wdata    = bus.wr_data;
                strb     = bus.wr_valid ? bus.wr_strb : '0;
                beat_acc = bus.wr_valid;
                if (!bus.wr_valid)
                    state_next = bus.rd_req_valid ? GNT_RD : IDLE;
                else if (hold_done && bus.rd_req_valid)
                    state_next = GNT_RD;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, last-grant tracking and saturating beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= LAST_WR;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state && state_next == GNT_RD) begin
                last_gnt <= LAST_RD;
                beat_cnt <= '0;
            end else if (state_next != state && state_next == GNT_WR) begin
                last_gnt <= LAST_WR;
                beat_cnt <= '0;
            end else if (beat_acc && beat_cnt != 8'hFF) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    // Read response valid tracks the memory read enable one cycle later.
    always_ff @(posedge clk) begin
        if (rst) resp_valid <= 1'b0;
        else     resp_valid <= ren;
    end

    assign bus.rd_req_ready  = rd_rdy;
    assign bus.wr_ready      = wr_rdy;
    assign bus.mem_ren       = ren;
    assign bus.mem_wen       = wen;
    assign bus.mem_addr      = addr;
    assign bus.mem_wdata     = wdata;
    assign bus.mem_strb      = strb;
    assign bus.rd_resp_valid = resp_valid;
    assign bus.rd_resp_data  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share stimulus; each has its own memory and a cycle-level reference model.
module tb_mem_port_arbiter;
    localparam int W   = 128;
    localparam int AWD = 32;
    localparam int A   = AWD - ($clog2(W) - 3);
    localparam int S   = W / 8;

    logic clk, rst;
    logic rv, wv;
    logic [A-1:0] ra, wa;
    logic [W-1:0] wd;
    logic [S-1:0] ws;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AWD)) bus0 ();
    mem_port_arbiter_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AWD)) bus1 ();

    mem_port_arbiter #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AWD), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    mem_port_arbiter #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AWD), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    logic         o_rrdy[2], o_wrdy[2], o_ren[2], o_wen[2], o_rvld[2];
    logic [A-1:0] o_addr[2];
    logic [W-1:0] o_wdata[2], o_rdata[2], mrd[2];
    logic [S-1:0] o_strb[2];
    logic [W-1:0] mem[2][64];

    assign bus0.rd_req_valid = rv;  assign bus1.rd_req_valid = rv;
    assign bus0.rd_req_addr  = ra;  assign bus1.rd_req_addr  = ra;
    assign bus0.wr_valid     = wv;  assign bus1.wr_valid     = wv;
    assign bus0.wr_addr      = wa;  assign bus1.wr_addr      = wa;
    assign bus0.wr_data      = wd;  assign bus1.wr_data      = wd;
    assign bus0.wr_strb      = ws;  assign bus1.wr_strb      = ws;
    assign bus0.mem_rdata    = mrd[0];
    assign bus1.mem_rdata    = mrd[1];

    assign o_rrdy[0] = bus0.rd_req_ready;  assign o_rrdy[1] = bus1.rd_req_ready;
    assign o_wrdy[0] = bus0.wr_ready;      assign o_wrdy[1] = bus1.wr_ready;
    assign o_ren[0]  = bus0.mem_ren;       assign o_ren[1]  = bus1.mem_ren;
    assign o_wen[0]  = bus0.mem_wen;       assign o_wen[1]  = bus1.mem_wen;
    assign o_rvld[0] = bus0.rd_resp_valid; assign o_rvld[1] = bus1.rd_resp_valid;
    assign o_addr[0] = bus0.mem_addr;      assign o_addr[1] = bus1.mem_addr;
    assign o_wdata[0] = bus0.mem_wdata;    assign o_wdata[1] = bus1.mem_wdata;
    assign o_rdata[0] = bus0.rd_resp_data; assign o_rdata[1] = bus1.rd_resp_data;
    assign o_strb[0] = bus0.mem_strb;      assign o_strb[1] = bus1.mem_strb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input int i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    // Memory array per instance: reloads its pattern on reset, 1-cycle read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) mem[k][i] <= pat(i);
            end else if (o_wen[k]) begin
                for (int b = 0; b < S; b++)
                    if (o_strb[k][b]) mem[k][o_addr[k][5:0]][b*8 +: 8] <= o_wdata[k][b*8 +: 8];
            end
            if (o_ren[k]) mrd[k] <= mem[k][o_addr[k][5:0]];
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: owner 0=none 1=read 2=write; run = beats taken in current grant.
    int           own[2], run[2];
    bit           lastw[2], known[2], rv_exp[2];
    logic [W-1:0] rd_exp[2];
    logic [W-1:0] shadow[2][64];

    task automatic model(input int k);
        int h, ng;
        bit e_ren, e_wen;
        logic [S-1:0] e_strb;
        h      = (k == 0) ? 4 : 1;
        e_ren  = (own[k] == 1) && rv;
        e_wen  = (own[k] == 2) && wv;
        e_strb = e_wen ? ws : '0;
        if (known[k]) begin
            check($sformatf("d%0d_rd_req_ready", k), W'(o_rrdy[k]), W'(own[k] == 1));
            check($sformatf("d%0d_wr_ready", k), W'(o_wrdy[k]), W'(own[k] == 2));
            check($sformatf("d%0d_mem_ren", k), W'(o_ren[k]), W'(e_ren));
            check($sformatf("d%0d_mem_wen", k), W'(o_wen[k]), W'(e_wen));
            check($sformatf("d%0d_mem_strb", k), W'(o_strb[k]), W'(e_strb));
            if (e_ren) check($sformatf("d%0d_rd_addr", k), W'(o_addr[k]), W'(ra));
            if (e_wen) begin
                check($sformatf("d%0d_wr_addr", k), W'(o_addr[k]), W'(wa));
                check($sformatf("d%0d_wdata", k), o_wdata[k], wd);
            end
            check($sformatf("d%0d_resp_valid", k), W'(o_rvld[k]), W'(rv_exp[k]));
            if (rv_exp[k]) check($sformatf("d%0d_resp_data", k), o_rdata[k], rd_exp[k]);
        end
        if (e_wen)
            for (int b = 0; b < S; b++)
                if (ws[b]) shadow[k][wa[5:0]][b*8 +: 8] = wd[b*8 +: 8];
        rv_exp[k] = !rst && e_ren && known[k];
        rd_exp[k] = shadow[k][ra[5:0]];
        if (rst) begin
            own[k] = 0; lastw[k] = 1'b1; run[k] = 0; known[k] = 1'b1;
            for (int i = 0; i < 64; i++) shadow[k][i] = pat(i);
        end else if (known[k]) begin
            ng = own[k];
            case (own[k])
                0: ng = (rv && wv) ? (lastw[k] ? 1 : 2) : rv ? 1 : wv ? 2 : 0;
                1: ng = !rv ? (wv ? 2 : 0) : (run[k] + 1 >= h && wv) ? 2 : 1;
                2: ng = !wv ? (rv ? 1 : 0) : (run[k] + 1 >= h && rv) ? 1 : 2;
                default: ng = 0;
            endcase
            if (ng != own[k] && ng != 0) begin
                lastw[k] = (ng == 2);
                run[k]   = 0;
            end else if (ng == own[k] && ng != 0) begin
                run[k]++;
            end
            own[k] = ng;
        end
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance.
    task automatic step(input logic r, input logic v_rd, input int a_rd, input logic v_wr,
                        input int a_wr, input logic [W-1:0] d, input logic [S-1:0] s);
        rst = r; rv = v_rd; ra = A'(a_rd); wv = v_wr; wa = A'(a_wr); wd = d; ws = s;
        #4;
        model(0);
        model(1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [W-1:0] sdata, smask;

    initial begin
        for (int k = 0; k < 2; k++) begin
            known[k] = 1'b0; own[k] = 0; run[k] = 0; lastw[k] = 1'b1; rv_exp[k] = 1'b0;
        end
        rst = 1'b1; rv = 1'b0; wv = 1'b0; ra = '0; wa = '0; wd = '0; ws = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, '0, '0);

        // Read-only burst, addresses 0..7 held until accepted.
        for (int i = 0; i < 9; i++) step(0, 1, (i == 0) ? 0 : i - 1, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);

        // Both requesters valid from the first cycle after reset.
        step(1, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 24; i++) step(0, 1, i, 1, 32 + i, rnd_data(), '1);
        step(0, 0, 0, 0, 0, '0, '0);

        // Partial-strobe write to word 5, then read it back.
        step(1, 0, 0, 0, 0, '0, '0);
        sdata = rnd_data();
        smask = {64'h0, 32'hFFFF_FFFF, 32'h0};
        step(0, 0, 0, 1, 5, sdata, 16'h00F0);
        step(0, 0, 0, 1, 5, sdata, 16'h00F0);
        step(0, 0, 0, 0, 0, '0, '0);
        check("strb_mem_word", mem[0][5], (pat(5) & ~smask) | (sdata & smask));
        check("strb_mem_neighbour", mem[0][4], pat(4));
        step(0, 1, 5, 0, 0, '0, '0);
        step(0, 1, 5, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);

        // Reset during the third read of a burst, then a tie.
        step(1, 0, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 0, '0, '0);
        step(0, 1, 1, 0, 0, '0, '0);
        step(1, 1, 2, 0, 0, '0, '0);
        step(0, 1, 3, 1, 40, rnd_data(), '1);
        step(0, 1, 3, 1, 40, rnd_data(), '1);
        step(0, 1, 4, 1, 41, rnd_data(), '1);
        step(0, 0, 0, 0, 0, '0, '0);

        // One-cycle gap in read valid with write idle.
        for (int i = 0; i < 4; i++) step(0, 1, 10 + i, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 20 + i, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, '0, '0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 63),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 63), rnd_data(), S'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
